// File: rtl/register_uart_reporter.sv
// register_uart_reporter: sends each new register1Value over UART 8N1 as uppercase hex followed by CR LF.
module register_uart_reporter #(
  parameter int REGISTER_WIDTH = 16,
  parameter int CLOCKS_PER_BIT = 434
) (
  input  logic                      clock,
  input  logic                      isReset,
  input  logic [REGISTER_WIDTH-1:0] register1Value,
  output logic                      txd,
  output logic                      busy,
  output logic                      pending
);
  localparam int HEX_DIGITS = (REGISTER_WIDTH + 3) / 4;
  localparam int TW = $clog2(CLOCKS_PER_BIT);
  localparam int CW = $clog2(HEX_DIGITS + 2);
  localparam logic [TW-1:0] T_LAST = TW'(CLOCKS_PER_BIT - 1);
  localparam logic [CW-1:0] CR_IDX = CW'(HEX_DIGITS);
  localparam logic [CW-1:0] LF_IDX = CW'(HEX_DIGITS + 1);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state, state_n;
  logic [REGISTER_WIDTH-1:0] last_value, snapshot, snapshot_n;
  logic [CW-1:0] char_index, char_index_n;
  logic [2:0] bit_index, bit_index_n;
  logic [TW-1:0] bit_timer, bit_timer_n;
  logic txd_n, busy_n, pending_n, bit_end;
  logic [HEX_DIGITS*4-1:0] shifted;
  logic [3:0] nibble;
  logic [7:0] char_code;
  // MSB-first digit selection: shift the current digit to the top of the zero-extended snapshot
  assign shifted = (HEX_DIGITS*4)'(snapshot) << {char_index, 2'b00};
  assign nibble = shifted[HEX_DIGITS*4-1 -: 4];
  assign char_code = char_index == CR_IDX ? 8'h0D : char_index == LF_IDX ? 8'h0A :
                     {4'h0, nibble} + (nibble < 4'd10 ? 8'h30 : 8'h37);
  assign bit_end = bit_timer == T_LAST;
  always_ff @(posedge clock) begin
    last_value <= register1Value;
    if (!isReset) begin
      state <= IDLE;
      txd <= 1'b1;
      busy <= 1'b0;
      pending <= 1'b1;
      snapshot <= '0;
      char_index <= '0;
      bit_index <= '0;
      bit_timer <= '0;
    end else begin
      state <= state_n;
      txd <= txd_n;
      busy <= busy_n;
      pending <= pending_n;
      snapshot <= snapshot_n;
      char_index <= char_index_n;
      bit_index <= bit_index_n;
      bit_timer <= bit_timer_n;
    end
  end
  always_comb begin
    state_n = state;
    txd_n = txd;
    busy_n = busy;
    snapshot_n = snapshot;
    char_index_n = char_index;
    bit_index_n = bit_index;
    bit_timer_n = (bit_end || state == IDLE) ? '0 : bit_timer + TW'(1);
    // a change on the same edge that starts a report keeps the next one queued
    pending_n = (register1Value != last_value) | (pending & (state != IDLE));
    case (state)
      IDLE: if (pending) begin
        state_n = START;
        txd_n = 1'b0;
        busy_n = 1'b1;
        snapshot_n = register1Value;
        char_index_n = '0;
      end
      START: if (bit_end) begin
        state_n = DATA;
        bit_index_n = '0;
        txd_n = char_code[0];
      end
      DATA: if (bit_end) begin
        if (bit_index == 3'd7) begin
          state_n = STOP;
          txd_n = 1'b1;
        end else begin
          bit_index_n = bit_index + 3'd1;
          txd_n = char_code[bit_index_n];
        end
      end
      STOP: if (bit_end) begin
        if (char_index < LF_IDX) begin
          state_n = START;
          char_index_n = char_index + CW'(1);
          txd_n = 1'b0;
        end else begin
          state_n = IDLE;
          busy_n = 1'b0;
        end
      end
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: doc/register_uart_reporter.md
Name: register_uart_reporter

Overview:
Downstream consumer of the CPU's register1Value output. Detects changes in register1Value and reports each new value over a UART 8N1 serial line. Each report is the value as uppercase ASCII hex, MSB digit first, followed by CR LF. Gives the board a human-readable trace of register 1 without a debugger.

Parameters:
REGISTER_WIDTH, 16, width of register1Value; must match the CPU.
CLOCKS_PER_BIT, 434, clock cycles per UART bit (50 MHz / 115200); minimum 2.
HEX_DIGITS, ceil(REGISTER_WIDTH/4), digits per report; derived, not overridden.

Ports:
clock  input  1  system clock; all logic on rising edge.
isReset  input  1  synchronous, active-low reset; block resets on any rising edge where isReset==0.
register1Value  input  REGISTER_WIDTH  value to monitor; synchronous to clock.
txd  output  1  UART transmit line; idle high.
busy  output  1  high while a report is being transmitted.
pending  output  1  high when a report is queued and not yet started.

Behaviour:
- Reset (isReset==0 at an edge):
  - txd=1, busy=0.
  - lastValue <= register1Value.
  - pending <= 1, so the first report after reset shows the boot value.
  - All counters = 0.
  - Reset mid-frame aborts immediately; no stop bit is completed.
- Change detect:
  - Every non-reset edge: lastValue <= register1Value.
  - If register1Value != lastValue, pending <= 1.
- FSM states: IDLE, START, DATA, STOP.
- IDLE:
  - If pending==1: snapshot <= register1Value sampled at this edge; charIndex <= 0; pending <= 0; busy <= 1; txd <= 0; go to START.
  - The edge after pending is first seen high is the first start-bit cycle (1-cycle latency).
- Set wins: if a change is detected on the same edge that clears pending, pending stays 1.
- START: txd=0 for CLOCKS_PER_BIT cycles, then DATA.
- DATA:
  - 8 bits, LSB first, each held CLOCKS_PER_BIT cycles.
  - bitIndex counts 0..7.
- STOP: txd=1 for CLOCKS_PER_BIT cycles.
  - If charIndex < HEX_DIGITS+1: charIndex++ and go to START, with no idle gap.
  - Else: busy <= 0 and go to IDLE.
- Character selection:
  - charIndex 0..HEX_DIGITS-1: hex nibble of snapshot, MSB nibble first. Top nibble is zero-extended when REGISTER_WIDTH is not a multiple of 4.
  - Nibble 0-9 maps to 0x30-0x39; nibble A-F maps to 0x41-0x46.
  - charIndex HEX_DIGITS: 0x0D.
  - charIndex HEX_DIGITS+1: 0x0A.
- Report duration: (HEX_DIGITS+2)*10*CLOCKS_PER_BIT cycles from the first start-bit cycle to the last stop-bit cycle inclusive.
- Changes during a report:
  - They do not alter the snapshot.
  - Any number of changes collapse into a single queued report.
  - The queued report uses register1Value sampled when it starts, i.e. the latest value.
- Back-to-back reports: the queued report starts on the edge after busy falls. txd stays high for exactly 1 cycle between the LF stop bit and the next start bit.
- Bit timer: counts 0..CLOCKS_PER_BIT-1 and wraps. It is the sole time base; no fractional-baud correction.

Test Plan:
- Power-on report (REGISTER_WIDTH=16, CLOCKS_PER_BIT=4):
  - Stimulus: hold register1Value=0x1A2F, pulse isReset low for 2 cycles, release.
  - Required: busy rises on the 2nd edge after release.
  - Required: decoded bytes are 0x31 0x41 0x32 0x46 0x0D 0x0A.
  - Required: busy is high for exactly 240 cycles; txd idles high afterwards.
- Single change:
  - Stimulus: after idle, step register1Value 0x1A2F -> 0x00B0.
  - Required: pending high 1 edge later; next report is "00B0\r\n".
  - Required: no further report while the value is stable for 1000 cycles.
- Coalescing:
  - Stimulus: during a report, write 0x0001, 0x0002, 0xFFFF at 20-cycle spacing.
  - Required: exactly one further report, "FFFF\r\n".
  - Required: its start bit begins with 1 idle-high cycle after the previous LF stop bit.
- Reset mid-frame:
  - Stimulus: assert isReset low during DATA of character 2.
  - Required: txd=1, busy=0 on that edge.
  - Required: after release, a full fresh report of the current value is sent.
- Odd width (REGISTER_WIDTH=10):
  - Stimulus: value 0x3FF, then 0x005.
  - Required: reports "3FF\r\n" and "005\r\n", 5 characters each (200 cycles at CLOCKS_PER_BIT=4).
- Bit timing:
  - Stimulus: CLOCKS_PER_BIT=2, value 0x0000.
  - Required: each txd level persists in multiples of exactly 2 cycles.
  - Required: the first character's bit sequence is 0,0,0,0,0,1,1,0,0,1 (start, 0x30 LSB first, stop).
